cpu_ctrl_unit: RTL

Microcoded sequencer for the CPU core datapath. It fetches 16-bit instructions over the core's bus handshake and executes each one. Execution drives the shared 32-bit data bus mux select, the register-file and special-register load enables, the PC counter controls and the add/sub mode. It sits beside the datapath inside the core and is the only source of all datapath control signals.

---
 rtl/cpu_ctrl_unit.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_ctrl_unit.sv
// Microcoded control sequencer for the CPU core datapath.
// Fetches 16-bit instructions over the bus handshake and drives every datapath enable.
module cpu_ctrl_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RUN,
    input  logic [15:0] INSTR_IN,
    input  logic        SLAVE_READY,
    output logic        BUS_VALID,
    output logic        BUS_WE,
    output logic [4:0]  CS,
    output logic [15:0] REG_EN,
    output logic        ADDER_IN_EN,
    output logic        ADDER_OUT_EN,
    output logic        ADDR_EN,
    output logic        ADD_SUB_MODE,
    output logic        PC_MODE,
    output logic        PC_EN,
    output logic        BUSY,
    output logic        HALTED,
    output logic        ILLEGAL_OP
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FETCH_A = 4'd1;
    localparam logic [3:0] S_FETCH_W = 4'd2;
    localparam logic [3:0] S_DECODE  = 4'd3;
    localparam logic [3:0] S_MOV     = 4'd4;
    localparam logic [3:0] S_ADD_A   = 4'd5;
    localparam logic [3:0] S_ADD_B   = 4'd6;
    localparam logic [3:0] S_ADD_C   = 4'd7;
    localparam logic [3:0] S_STORE_A = 4'd8;
    localparam logic [3:0] S_STORE_W = 4'd9;
    localparam logic [3:0] S_JMP     = 4'd10;
    localparam logic [3:0] S_HALT    = 4'd11;

    localparam logic [4:0] CS_ADDER = 5'd16;
    localparam logic [4:0] CS_PC    = 5'd17;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_MOV   = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_STORE = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'hF;

    logic [3:0]  r_state;
    logic [3:0]  w_next;
    logic [15:0] r_ir;

    logic [3:0]  w_op;
    logic [3:0]  w_rd;
    logic [3:0]  w_rs;
    logic [15:0] w_rd_hot;
    logic        w_legal;
    logic [3:0]  w_bound;

    assign w_op     = r_ir[15:12];
    assign w_rd     = r_ir[11:8];
    assign w_rs     = r_ir[7:4];
    assign w_rd_hot = 16'h0001 << w_rd;

    // RUN is only looked at between instructions
    assign w_bound  = RUN ? S_FETCH_A : S_IDLE;

    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            OP_NOP, OP_MOV, OP_ADD, OP_SUB,
            OP_STORE, OP_JMP, OP_HALT: w_legal = 1'b1;
            default:                   w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH_W && SLAVE_READY)
                r_ir <= INSTR_IN;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (RUN)
                    w_next = S_FETCH_A;
            end
            S_FETCH_A: w_next = S_FETCH_W;
            S_FETCH_W: begin
                if (SLAVE_READY)
                    w_next = S_DECODE;
            end
            S_DECODE: begin
                case (w_op)
                    OP_MOV:         w_next = S_MOV;
                    OP_ADD, OP_SUB: w_next = S_ADD_A;
                    OP_STORE:       w_next = S_STORE_A;
                    OP_JMP:         w_next = S_JMP;
                    OP_HALT:        w_next = S_HALT;
                    default:        w_next = w_bound;
                endcase
            end
            S_MOV:     w_next = w_bound;
            S_ADD_A:   w_next = S_ADD_B;
            S_ADD_B:   w_next = S_ADD_C;
            S_ADD_C:   w_next = w_bound;
            S_STORE_A: w_next = S_STORE_W;
            S_STORE_W: begin
                if (SLAVE_READY)
                    w_next = w_bound;
            end
            S_JMP:     w_next = w_bound;
            S_HALT: begin
                if (!RUN)
                    w_next = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        BUS_VALID    = 1'b0;
        BUS_WE       = 1'b0;
        CS           = 5'd0;
        REG_EN       = 16'h0000;
        ADDER_IN_EN  = 1'b0;
        ADDER_OUT_EN = 1'b0;
        ADDR_EN      = 1'b0;
        ADD_SUB_MODE = 1'b0;
        PC_MODE      = 1'b0;
        PC_EN        = 1'b0;
        BUSY         = 1'b0;
        HALTED       = 1'b0;
        ILLEGAL_OP   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
            end
            S_FETCH_A: begin
                BUSY    = 1'b1;
                CS      = CS_PC;
                ADDR_EN = 1'b1;
            end
            S_FETCH_W: begin
                BUSY      = 1'b1;
                BUS_VALID = 1'b1;
                PC_EN     = SLAVE_READY;
            end
            S_DECODE: begin
                BUSY       = 1'b1;
                ILLEGAL_OP = ~w_legal;
            end
            S_MOV: begin
                BUSY   = 1'b1;
                CS     = {1'b0, w_rs};
                REG_EN = w_rd_hot;
            end
            S_ADD_A: begin
                BUSY        = 1'b1;
                CS          = {1'b0, w_rd};
                ADDER_IN_EN = 1'b1;
            end
            S_ADD_B: begin
                BUSY         = 1'b1;
                CS           = {1'b0, w_rs};
                ADDER_OUT_EN = 1'b1;
                ADD_SUB_MODE = (w_op == OP_ADD);
            end
            S_ADD_C: begin
                BUSY   = 1'b1;
                CS     = CS_ADDER;
                REG_EN = w_rd_hot;
            end
            S_STORE_A: begin
                BUSY    = 1'b1;
                CS      = {1'b0, w_rs};
                ADDR_EN = 1'b1;
            end
            S_STORE_W: begin
                BUSY      = 1'b1;
                CS        = {1'b0, w_rd};
                BUS_VALID = 1'b1;
                BUS_WE    = 1'b1;
            end
            S_JMP: begin
                BUSY    = 1'b1;
                CS      = {1'b0, w_rs};
                PC_MODE = 1'b1;
                PC_EN   = 1'b1;
            end
            S_HALT: begin
                HALTED = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
